// File: rtl/div_pkg.sv
// Shared encodings for the RV32M divider.
// Optional early-out for special cases: DIV_EARLY_OUT_EN.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  function automatic logic is_rem(op_t op);
    return op[1];
  endfunction

  function automatic logic is_signed(op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between execute and the divider.
// Carries start, op, operands, busy, done and result.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit_subtractor.sv
// Borrow-chain ripple subtractor: diff = a - b, bout = final borrow.
// Used as the trial subtraction inside the divider.
module subtractor #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  logic [WIDTH:0] br;

  always_comb begin
    br   = '0;
    diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) |
                 (~(a[i] ^ b[i]) & br[i]);
    end
  end

  assign bout = br[WIDTH];
endmodule

// File: rtl/div_unit.sv
// Restoring RV32M divider, one quotient bit per clock.
// DIV_EARLY_OUT_EN: special cases finish one cycle after start.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  op_t              opq;
  logic             qneg, rneg, ovf;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] quo, rem, dsr;
  logic [CW-1:0]    cnt;

  op_t              op_in;
  logic             sa, sb, dz, ov, early;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] spec_res;
  logic [WIDTH-1:0] sel, fix_res;
  logic [WIDTH:0]   sh, dif;
  logic             bo, take;

  assign op_in = op_t'(bus.op);
  assign sa    = is_signed(op_in) & bus.dividend[WIDTH-1];
  assign sb    = is_signed(op_in) & bus.divisor[WIDTH-1];
  assign mag_a = sa ? -bus.dividend : bus.dividend;
  assign mag_b = sb ? -bus.divisor : bus.divisor;
  assign dz    = (bus.divisor == '0);
  assign ov    = is_signed(op_in) &
                 (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &
                 (&bus.divisor);

  assign spec_res = is_rem(op_in) ?
                    (dz ? bus.dividend : '0) :
                    (dz ? '1 : bus.dividend);

`ifdef DIV_EARLY_OUT_EN
  assign early = dz | ov;
`else
  assign early = 1'b0;
`endif

  assign sh = {rem, quo[WIDTH-1]};

  subtractor #(.WIDTH(WIDTH+1)) u_sub (
    .a    (sh),
    .b    ({1'b0, dsr}),
    .diff (dif),
    .bout (bo)
  );

  // bit WIDTH of the difference mirrors the borrow
  assign take = ~bo & ~dif[WIDTH];

  always_comb begin
    sel     = is_rem(opq) ? rem : quo;
    fix_res = (is_rem(opq) ? rneg : qneg) ? -sel : sel;
    if (ovf)
      fix_res = is_rem(opq) ? '0 :
                {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      opq    <= OP_DIV;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      ovf    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start && early) begin
            done_q <= 1'b1;
            res_q  <= spec_res;
          end else if (bus.start) begin
            state  <= ST_CALC;
            busy_q <= 1'b1;
            opq    <= op_in;
            qneg   <= (sa ^ sb) & ~dz;
            rneg   <= sa;
            ovf    <= ov;
            quo    <= mag_a;
            dsr    <= mag_b;
            rem    <= '0;
            cnt    <= '0;
          end
        end
        ST_CALC: begin
          rem <= take ? dif[WIDTH-1:0] : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1))
            state <= ST_FIX;
        end
        ST_FIX: begin
          res_q  <= fix_res;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed RV32M cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int L_SP = 1;
`else
  localparam int L_SP = 34;
`endif
  localparam int L_N = 34;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit special(logic [1:0] op, logic [31:0] a,
                                 logic [31:0] b);
    return (b == 0) ||
      (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(logic [1:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
    longint x, y, r;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      x = longint'(a);
      y = longint'(b);
    end else begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return op[1] ? 32'h0 : a;
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    r = op[1] ? (x % y) : (x / y);
    return r[31:0];
  endfunction

  function automatic int lat_of(logic [1:0] op, logic [31:0] a,
                                logic [31:0] b);
    return special(op, a, b) ? L_SP : L_N;
  endfunction

  // reference model and per-cycle compare
  bit          pending = 0;
  bit          early = 0;
  int          due = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] held = '0;
  bit          hold_ok = 1;

  always @(negedge clk) begin
    bit xd, xb;
    int l;
    if (!rst_n) begin
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
      chk("rst_result", bus.result, 0);
      pending = 0;
      held    = '0;
      hold_ok = 1;
    end else begin
      xd = pending && cyc == due;
      xb = pending && cyc < due && !early;
      chk("done", {31'b0, bus.done}, {31'b0, xd});
      chk("busy", {31'b0, bus.busy}, {31'b0, xb});
      if (xd) begin
        chk("result", bus.result, exp_res);
        held    = exp_res;
        hold_ok = 1;
        pending = 0;
      end else if (hold_ok) begin
        chk("hold", bus.result, held);
      end
      if (bus.start && !xb) begin
        exp_res = ref_res(bus.op, bus.dividend, bus.divisor);
        l       = lat_of(bus.op, bus.dividend, bus.divisor);
        pending = 1;
        early   = (l == 1);
        due     = cyc + l;
        hold_ok = 0;
      end
    end
  end

  task automatic do_op(logic [1:0] op, logic [31:0] a,
                       logic [31:0] b, logic [31:0] exp,
                       int lat, bit inject);
    int acc, n, nb;
    bit got;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.start    = 1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    acc = cyc;
    @(posedge clk);
    #1;
    bus.start    = 0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    if (inject) begin
      repeat (9) @(posedge clk);
      #1;
      bus.start    = 1;
      bus.op       = 2'b10;
      bus.dividend = 32'd12345;
      bus.divisor  = 32'd11;
      @(posedge clk);
      #1;
      bus.start = 0;
    end
    got = 0;
    nb  = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.done) got = 1;
      else if (bus.busy) nb++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d a=%h b=%h", op, a, b);
    end else begin
      chk("dir_result", bus.result, exp);
      chk("dir_latency", 32'(cyc - acc), 32'(lat));
      if (!inject) chk("dir_busy_cycles", 32'(nb), 32'(lat - 1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    rst_n        = 0;
    bus.start    = 0;
    bus.op       = 0;
    bus.dividend = 0;
    bus.divisor  = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    chk("m_divu", ref_res(2'b01, 100, 7), 32'd14);
    chk("m_rem", ref_res(2'b10, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("m_div", ref_res(2'b00, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("m_ovf", ref_res(2'b00, 32'h8000_0000, 32'hFFFF_FFFF),
        32'h8000_0000);
    chk("m_remu0", ref_res(2'b11, 5, 0), 32'd5);
    chk("m_div0", ref_res(2'b00, 32'hFFFF_FFF9, 0), 32'hFFFF_FFFF);

    do_op(2'b01, 100, 7, 32'd14, L_N, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, L_N, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, L_N, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, L_SP, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, L_SP, 0);
    do_op(2'b01, 5, 0, 32'hFFFF_FFFF, L_SP, 0);
    do_op(2'b11, 5, 0, 32'd5, L_SP, 0);
    do_op(2'b00, 32'hFFFF_FFF9, 0, 32'hFFFF_FFFF, L_SP, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, L_SP, 0);
    do_op(2'b01, 100, 7, 32'd14, L_N, 1);

    // abort a DIVU mid-flight
    @(posedge clk);
    #1;
    bus.start    = 1;
    bus.op       = 2'b01;
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (14) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("async_busy", {31'b0, bus.busy}, 0);
    chk("async_done", {31'b0, bus.done}, 0);
    chk("async_result", bus.result, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("no_done_after_abort", 32'(nd), 0);
    do_op(2'b01, 1000, 10, 32'd100, L_N, 0);

    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      bus.start    = ($urandom % 3 == 0);
      bus.op       = 2'($urandom);
      bus.dividend = pick();
      bus.divisor  = pick();
    end
    bus.start = 0;
    repeat (40) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
